// File: rtl/clk_gate_ctrl.sv
// Burst clock-enable controller for clk_buf.ce: holds ce high for exactly len cycles, then a GAP-cycle cool-down.
// Latency: ce rises the cycle after start is sampled in IDLE; done/abrt pulse the cycle after the last enabled cycle.
// Backpressure: none; start is accepted only in IDLE and is dropped (not queued) while busy.
//
// Ports:
//   clk   controller clock, same clock as the driven clk_buf input
//   rst   synchronous active-high reset, overrides every other input
//   start burst request, sampled only in IDLE, together with len
//   len   burst length in cycles; 0 gives a done pulse with no enabled cycle
//   stop  aborts a running burst; ignored outside RUN
//   ce    registered clock enable for clk_buf.ce
//   busy  high while in RUN or GAP
//   done  one-cycle pulse at the end of every burst (normal or aborted)
//   abrt  one-cycle pulse alongside done when stop ended the burst early
//   cnt   remaining enabled cycles while in RUN, 0 otherwise
module clk_gate_ctrl #(
    parameter int CNT_W = 16,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             stop,
    output logic             ce,
    output logic             busy,
    output logic             done,
    output logic             abrt,
    output logic [CNT_W-1:0] cnt
);

    // Gap counter holds values GAP-1 .. 0; keep at least one bit when GAP is 0.
    localparam int GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int GAP_LDI  = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [GW-1:0] GAP_LD = GW'(GAP_LDI);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] rem;
    logic [GW-1:0]    gcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            rem   <= '0;
            gcnt  <= '0;
            ce    <= 1'b0;
            done  <= 1'b0;
            abrt  <= 1'b0;
        end else begin
            done <= 1'b0;
            abrt <= 1'b0;
            case (state)
                S_IDLE: begin
                    // stop has priority over start, so start+stop does nothing
                    if (start && !stop) begin
                        if (len != '0) begin
                            state <= S_RUN;
                            rem   <= len;
                            ce    <= 1'b1;
                        end else begin
                            // zero-length burst: report completion, still honour the gap
                            done <= 1'b1;
                            if (GAP == 0) begin
                                state <= S_IDLE;
                            end else begin
                                state <= S_GAP;
                                gcnt  <= GAP_LD;
                            end
                        end
                    end
                end
                S_RUN: begin
                    // rem==1 is the last enabled cycle; a stop there is a normal end
                    if (rem <= 1 || stop) begin
                        ce   <= 1'b0;
                        done <= 1'b1;
                        abrt <= (rem > 1);
                        rem  <= '0;
                        if (GAP == 0) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_GAP;
                            gcnt  <= GAP_LD;
                        end
                    end else begin
                        rem <= rem - 1'b1;
                    end
                end
                S_GAP: begin
                    if (gcnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    rem   <= '0;
                    gcnt  <= '0;
                    ce    <= 1'b0;
                end
            endcase
        end
    end

    // Pure decodes of the state register; ce itself is a direct flop output.
    assign busy = (state != S_IDLE);
    assign cnt  = (state == S_RUN) ? rem : '0;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: one instance with GAP=2, one with GAP=0.
// Stimulus pushes hand-derived expected outputs per cycle; a monitor pops and compares at negedge.
// Bounded by a watchdog so the run always reaches the summary line.
module tb_clk_gate_ctrl;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // GAP=2 instance
    logic         rst, start, stop;
    logic [W-1:0] len;
    logic         ce, busy, done, abrt;
    logic [W-1:0] cnt;

    // GAP=0 instance
    logic         rst0, start0, stop0;
    logic [W-1:0] len0;
    logic         ce0, busy0, done0, abrt0;
    logic [W-1:0] cnt0;

    clk_gate_ctrl #(.CNT_W(W), .GAP(2)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .stop(stop),
        .ce(ce), .busy(busy), .done(done), .abrt(abrt), .cnt(cnt)
    );

    clk_gate_ctrl #(.CNT_W(W), .GAP(0)) dut0 (
        .clk(clk), .rst(rst0), .start(start0), .len(len0), .stop(stop0),
        .ce(ce0), .busy(busy0), .done(done0), .abrt(abrt0), .cnt(cnt0)
    );

    typedef struct packed {
        logic         ce;
        logic         busy;
        logic         done;
        logic         abrt;
        logic [W-1:0] cnt;
    } obs_t;

    obs_t  qa[$];
    obs_t  qb[$];
    string ta[$];
    string tb[$];
    string tag;

    int total = 0;
    int bad   = 0;

    function automatic obs_t mk(bit c, bit b, bit d, bit a, int n);
        obs_t o;
        o.ce   = c;
        o.busy = b;
        o.done = d;
        o.abrt = a;
        o.cnt  = W'(n);
        return o;
    endfunction

    // Drive GAP=2 inputs for one edge; e is the output expected right after that edge.
    task automatic cyc(bit r, bit st, int ln, bit sp, obs_t e);
        rst   = r;
        start = st;
        len   = W'(ln);
        stop  = sp;
        @(posedge clk);
        qa.push_back(e);
        ta.push_back(tag);
        #1;
    endtask

    task automatic cyc0(bit r, bit st, int ln, bit sp, obs_t e);
        rst0   = r;
        start0 = st;
        len0   = W'(ln);
        stop0  = sp;
        @(posedge clk);
        qb.push_back(e);
        tb.push_back(tag);
        #1;
    endtask

    obs_t  ea, aa, eb, ab;
    string sa, sb;

    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            sa = ta.pop_front();
            aa = '{ce, busy, done, abrt, cnt};
            total++;
            if (aa !== ea) begin
                bad++;
                $display("FAIL gap2/%s t=%0t got ce=%b busy=%b done=%b abrt=%b cnt=%0d need ce=%b busy=%b done=%b abrt=%b cnt=%0d",
                         sa, $time, aa.ce, aa.busy, aa.done, aa.abrt, aa.cnt,
                         ea.ce, ea.busy, ea.done, ea.abrt, ea.cnt);
            end
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            sb = tb.pop_front();
            ab = '{ce0, busy0, done0, abrt0, cnt0};
            total++;
            if (ab !== eb) begin
                bad++;
                $display("FAIL gap0/%s t=%0t got ce=%b busy=%b done=%b abrt=%b cnt=%0d need ce=%b busy=%b done=%b abrt=%b cnt=%0d",
                         sb, $time, ab.ce, ab.busy, ab.done, ab.abrt, ab.cnt,
                         eb.ce, eb.busy, eb.done, eb.abrt, eb.cnt);
            end
        end
    end

    initial begin
        #3_000_000;
        bad++;
        $display("FAIL watchdog: run did not finish, got time=%0t required < 3000000", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; len = '0;
        rst0 = 1'b1; start0 = 1'b0; stop0 = 1'b0; len0 = '0;

        // reset state
        tag = "reset";
        cyc(1, 0, 0, 0, mk(0, 0, 0, 0, 0));
        cyc(1, 1, 5, 0, mk(0, 0, 0, 0, 0));
        cyc(0, 0, 0, 0, mk(0, 0, 0, 0, 0));
        tag = "idle_stop";
        cyc(0, 0, 0, 1, mk(0, 0, 0, 0, 0));

        // len=5: ce 5 cycles with cnt 5..1, done, 2 gap cycles busy
        tag = "len5";
        cyc(0, 1, 5, 0, mk(1, 1, 0, 0, 5));
        for (int i = 4; i >= 1; i--) cyc(0, 0, 0, 0, mk(1, 1, 0, 0, i));
        cyc(0, 0, 0, 0, mk(0, 1, 1, 0, 0));
        cyc(0, 0, 0, 0, mk(0, 1, 0, 0, 0));
        cyc(0, 0, 0, 0, mk(0, 0, 0, 0, 0));

        // len=0: done next cycle, no ce, busy 2 cycles
        tag = "len0";
        cyc(0, 1, 0, 0, mk(0, 1, 1, 0, 0));
        cyc(0, 0, 0, 0, mk(0, 1, 0, 0, 0));
        cyc(0, 0, 0, 0, mk(0, 0, 0, 0, 0));

        // len=10 aborted during the 4th ce cycle
        tag = "abort4";
        cyc(0, 1, 10, 0, mk(1, 1, 0, 0, 10));
        cyc(0, 0, 0, 0, mk(1, 1, 0, 0, 9));
        cyc(0, 0, 0, 0, mk(1, 1, 0, 0, 8));
        cyc(0, 0, 0, 0, mk(1, 1, 0, 0, 7));
        cyc(0, 0, 0, 1, mk(0, 1, 1, 1, 0));
        cyc(0, 0, 0, 0, mk(0, 1, 0, 0, 0));
        cyc(0, 0, 0, 0, mk(0, 0, 0, 0, 0));

        // stop on the last ce cycle is a normal completion
        tag = "stop_last";
        cyc(0, 1, 10, 0, mk(1, 1, 0, 0, 10));
        for (int i = 9; i >= 1; i--) cyc(0, 0, 0, 0, mk(1, 1, 0, 0, i));
        cyc(0, 0, 0, 1, mk(0, 1, 1, 0, 0));
        cyc(0, 0, 0, 1, mk(0, 1, 0, 0, 0));
        cyc(0, 0, 0, 0, mk(0, 0, 0, 0, 0));

        // start held through RUN and GAP: ignored until busy falls
        tag = "start_held";
        cyc(0, 1, 2, 0, mk(1, 1, 0, 0, 2));
        cyc(0, 1, 2, 0, mk(1, 1, 0, 0, 1));
        cyc(0, 1, 2, 0, mk(0, 1, 1, 0, 0));
        cyc(0, 1, 2, 0, mk(0, 1, 0, 0, 0));
        cyc(0, 1, 2, 0, mk(0, 0, 0, 0, 0));
        cyc(0, 1, 2, 0, mk(1, 1, 0, 0, 2));
        cyc(0, 0, 0, 0, mk(1, 1, 0, 0, 1));
        cyc(0, 0, 0, 0, mk(0, 1, 1, 0, 0));
        cyc(0, 0, 0, 0, mk(0, 1, 0, 0, 0));
        cyc(0, 0, 0, 0, mk(0, 0, 0, 0, 0));

        // reset during the 2nd ce cycle of len=8: no done afterwards
        tag = "rst_run";
        cyc(0, 1, 8, 0, mk(1, 1, 0, 0, 8));
        cyc(0, 0, 0, 0, mk(1, 1, 0, 0, 7));
        cyc(1, 0, 0, 0, mk(0, 0, 0, 0, 0));
        cyc(0, 0, 0, 0, mk(0, 0, 0, 0, 0));
        cyc(0, 0, 0, 0, mk(0, 0, 0, 0, 0));

        // start and stop together in IDLE: nothing happens
        tag = "start_stop";
        cyc(0, 1, 5, 1, mk(0, 0, 0, 0, 0));
        cyc(0, 0, 0, 0, mk(0, 0, 0, 0, 0));

        // maximum burst length
        tag = "len_max";
        cyc(0, 1, 65535, 0, mk(1, 1, 0, 0, 65535));
        for (int i = 65534; i >= 1; i--) cyc(0, 0, 0, 0, mk(1, 1, 0, 0, i));
        cyc(0, 0, 0, 0, mk(0, 1, 1, 0, 0));
        cyc(0, 0, 0, 0, mk(0, 1, 0, 0, 0));
        cyc(0, 0, 0, 0, mk(0, 0, 0, 0, 0));

        // GAP=0 instance
        tag = "g0_reset";
        cyc0(1, 0, 0, 0, mk(0, 0, 0, 0, 0));
        cyc0(0, 0, 0, 0, mk(0, 0, 0, 0, 0));

        // start held with len=3: 3 ce cycles then one low (done) cycle, repeated
        tag = "g0_b2b";
        for (int r = 0; r < 3; r++) begin
            cyc0(0, 1, 3, 0, mk(1, 1, 0, 0, 3));
            cyc0(0, 1, 3, 0, mk(1, 1, 0, 0, 2));
            cyc0(0, 1, 3, 0, mk(1, 1, 0, 0, 1));
            cyc0(0, 1, 3, 0, mk(0, 0, 1, 0, 0));
        end
        cyc0(0, 0, 0, 0, mk(0, 0, 0, 0, 0));

        tag = "g0_len0";
        cyc0(0, 1, 0, 0, mk(0, 0, 1, 0, 0));
        cyc0(0, 0, 0, 0, mk(0, 0, 0, 0, 0));

        tag = "g0_abort";
        cyc0(0, 1, 4, 0, mk(1, 1, 0, 0, 4));
        cyc0(0, 0, 0, 1, mk(0, 0, 1, 1, 0));
        cyc0(0, 0, 0, 0, mk(0, 0, 0, 0, 0));

        repeat (3) @(negedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL drain: got pending=%0d required 0", qa.size() + qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Burst controller that drives the `ce` input of the global clock buffer with clock enable (`clk_buf`). On a start request it holds the enable high for exactly `len` cycles of its own clock. It then enforces a minimum number of disabled cycles before the next burst. It sits beside `clk_buf` in the clocking subsystem and gives the design on/off clocking of downstream sampling logic in exact cycle counts.

## Interface
Parameters:
- `CNT_W`, 16: width of burst length and remaining-count fields.
- `GAP`, 2: minimum number of cycles with `ce`=0 after each burst before a new start is accepted; 0 is legal.

Ports:
- `clk`  in  1  controller clock; same clock as the `in` of the driven `clk_buf`.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  burst request; sampled only in IDLE.
- `len`  in  CNT_W  burst length in cycles, sampled with `start`.
- `stop`  in  1  abort the current burst.
- `ce`  out  1  clock enable to `clk_buf.ce`; registered, glitch-free.
- `busy`  out  1  high in RUN and GAP.
- `done`  out  1  one-cycle pulse at burst end, whether normal or aborted.
- `abrt`  out  1  one-cycle pulse coincident with `done` when the burst was ended by `stop`.
- `cnt`  out  CNT_W  remaining enabled cycles; 0 outside RUN.

## Operation
- States: IDLE, RUN, GAP. Registers: state, `rem` (CNT_W), gap counter (width is ceil(log2(GAP+1)), minimum 1), plus `ce`, `done` and `abrt` flops.
- Reset: state is IDLE, `rem` is 0, gap counter is 0. All outputs are 0 in the cycle after a `rst`-high edge. `rst` overrides every other input.
- IDLE, `start`=1, `stop`=0, `len`=N>0: go to RUN with `rem`=N and `ce`=1.
- IDLE, `start`=1, `stop`=0, `len`=0: no enable cycle. Pulse `done` with `abrt`=0, then enter GAP, or IDLE when GAP=0.
- IDLE with `start`=`stop`=1: `stop` wins and nothing happens.
- RUN: `rem` decrements at each edge.
  - At the edge where `rem`=1: `ce` goes to 0, `done` pulses, state becomes GAP (or IDLE when GAP=0).
  - `stop`=1 in RUN with `rem`>1: same exit, with `abrt` pulsing alongside `done`. `rem` is cleared.
  - `stop`=1 when `rem`=1: this is a normal completion and `abrt` stays 0.
- GAP: the counter loads GAP-1 on entry and counts to 0, giving exactly GAP cycles in GAP. Then IDLE.
- `start` outside IDLE is ignored, not queued. `stop` outside RUN is ignored.
- `cnt` = `rem` in RUN, 0 otherwise.
- `ce` comes only from a flop and never from combinational logic.
- No arithmetic wrap: `rem` never decrements below 1 in RUN.

## Timing
- Let `start` be sampled high at edge k with `len`=N>0.
  - `ce`=1 and `busy`=1 for cycles k+1 to k+N inclusive, i.e. exactly N gated clock cycles.
  - `done`=1 in cycle k+N+1 only.
  - `busy` stays 1 through cycle k+N+GAP. The earliest new start is sampled at edge k+N+GAP+1 (at edge k+N+1 when GAP=0).
- `len`=0 at edge k: `done`=1 in cycle k+1, `ce` stays 0, `busy`=1 for cycles k+1 to k+GAP.
- `stop` sampled at edge j during RUN: `ce`=0 from cycle j+1, and `done`/`abrt` pulse in cycle j+1.
- `rst` sampled during RUN at edge r: `ce`=0 from cycle r+1, with no `done` pulse.
- Back-to-back with GAP=0: `ce` drops for exactly one cycle between bursts, which is the `done` cycle.
- Maximum burst is 2^CNT_W-1 cycles.

## Test plan
- Reset then `start` with `len`=5, GAP=2: `ce` high for exactly 5 cycles, `cnt` goes 5,4,3,2,1. `done` pulses once, `busy` falls 2 cycles after `done`, `abrt`=0.
- `len`=0: `done` pulses in the next cycle, `ce` is never high, `busy` is high 2 cycles.
- `start` `len`=10, `stop` on the 4th `ce` cycle: 4 `ce` cycles, then `done`=`abrt`=1 for one cycle and `cnt`=0. A `stop` on the last `ce` cycle gives 10 cycles with `abrt`=0.
- `start` held continuously with `len`=3 and GAP=0: pattern of 3 `ce` cycles then 1 low cycle, repeated. With GAP=2, `start` asserted during GAP is ignored and the next burst begins only after `busy` falls.
- `rst` asserted on the 2nd `ce` cycle of a `len`=8 burst: `ce`, `busy` and `cnt` are 0 in the next cycle with no `done`. A `start`+`stop` in the same IDLE cycle leaves `busy`=0.
- `len`=65535 with CNT_W=16: exactly 65535 `ce` cycles and no wrap.
